// File: rtl/prog_clock_divider_pkg.sv
// Shared constants and types for the programmable clock divider.
// Optional feature macro: PROG_CLKDIV_TICK_EN (enables the per-channel tick outputs).
package prog_clock_divider_pkg;

    // Half-period divisor loaded into every channel at reset.
    localparam int DEFAULT_DIV_PKG = 16384;

    // Upper bound on the number of channels one divider instance may carry.
    localparam int MAX_NUM_CH = 16;

    // Counter width the default configuration is built with.
    localparam int PKG_CNT_W = 16;

    // Per-channel state at the default counter width. Each channel keeps the
    // same fields, in this order, at its own parameterised width:
    //   n       active half-period divisor (0 = stopped)
    //   cnt     position within the current half-period
    //   p       pending divisor waiting for the next boundary
    //   f       pending flag
    //   clk_out divided clock level
    typedef struct packed {
        logic [PKG_CNT_W-1:0] n;
        logic [PKG_CNT_W-1:0] cnt;
        logic [PKG_CNT_W-1:0] p;
        logic                 f;
        logic                 clk_out;
    } ch_state_t;

endpackage

// File: rtl/prog_clock_divider_channel.sv
// One divided-clock channel: half-period counter, pending-divisor handling,
// phase-alignment and an optional registered rising-edge tick.
// Optional feature macro: PROG_CLKDIV_TICK_EN.
module clkdiv_channel
    import prog_clock_divider_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = DEFAULT_DIV_PKG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             we,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             clk_out,
    output logic             tick,
    output logic             cfg_pending
);

    typedef struct packed {
        logic [CNT_W-1:0] n;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] p;
        logic             f;
        logic             clk_out;
    } state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam state_t RST_STATE = '{
        n:       CNT_W'(DEFAULT_DIV),
        cnt:     '0,
        p:       '0,
        f:       1'b0,
        clk_out: 1'b0
    };

    state_t           cur;
    state_t           nxt;
    logic             boundary;
    logic             do_apply;
    logic [CNT_W-1:0] apply_val;

    // Next-state: sync beats counting; a write landing on an apply event
    // bypasses the pending register so the newest value wins.
    always_comb begin
        nxt       = cur;
        boundary  = en && (cur.n != '0) && (cur.cnt == cur.n - ONE);
        do_apply  = we || cur.f;
        apply_val = we ? cfg_div : cur.p;

        if (we) begin
            nxt.p = cfg_div;
            nxt.f = 1'b1;
        end

        if (sync) begin
            nxt.cnt     = '0;
            nxt.clk_out = 1'b0;
            if (do_apply) begin
                nxt.n = apply_val;
                nxt.f = 1'b0;
            end
        end else if (boundary) begin
            nxt.cnt     = '0;
            nxt.clk_out = ~cur.clk_out;
            if (do_apply) begin
                nxt.n = apply_val;
                nxt.f = 1'b0;
                if (apply_val == '0) begin
                    nxt.clk_out = 1'b0;
                end
            end
        end else if (cur.n == '0) begin
            // Stopped channel: a pending value is taken one cycle after its write.
            nxt.cnt     = '0;
            nxt.clk_out = 1'b0;
            if (cur.f) begin
                nxt.n = apply_val;
                nxt.f = 1'b0;
            end
        end else if (en) begin
            nxt.cnt = cur.cnt + ONE;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur <= RST_STATE;
        end else begin
            cur <= nxt;
        end
    end

    assign clk_out     = cur.clk_out;
    assign cfg_pending = cur.f;

`ifdef PROG_CLKDIV_TICK_EN
    logic tick_q;
    logic tick_nxt;

    // A rise of the divided clock is the only thing that raises tick.
    always_comb begin
        tick_nxt = ~cur.clk_out & nxt.clk_out;
    end

    // Tick register, cleared by reset so a truncated period never pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick_nxt;
        end
    end

    assign tick = tick_q;
`else
    assign tick = 1'b0;
`endif

endmodule

// File: rtl/prog_clock_divider.sv
// Programmable multi-channel clock divider: decodes divisor writes to one of
// NUM_CH independent channels, each producing a 50% duty divided clock.
// Optional feature macro: PROG_CLKDIV_TICK_EN (per-channel rising-edge tick).
module prog_clock_divider
    import prog_clock_divider_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = DEFAULT_DIV_PKG,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              sync,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] cfg_pending
);

    logic [NUM_CH-1:0] ch_we;

    // One channel per index; a write whose cfg_ch matches no index is dropped.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign ch_we[i] = cfg_we && (cfg_ch == CH_W'(i));

        clkdiv_channel #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .en          (en),
            .sync        (sync),
            .we          (ch_we[i]),
            .cfg_div     (cfg_div),
            .clk_out     (clk_out[i]),
            .tick        (tick[i]),
            .cfg_pending (cfg_pending[i])
        );
    end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Self-checking bench for prog_clock_divider: directed scenarios plus a
// randomized run, every cycle compared against a behavioural channel model.
module tb_prog_clock_divider;

    localparam int NUM_CH  = 3;
    localparam int CNT_W   = 16;
    localparam int DEF_DIV = 16384;
    localparam int CH_W    = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              sync;
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] cfg_pending;

    int total = 0;
    int bad   = 0;

    // Behavioural model: divisor, elapsed cycles in the half period, level,
    // tick, pending flag/value per channel.
    int m_n[NUM_CH];
    int m_pos[NUM_CH];
    int m_pv[NUM_CH];
    bit m_lvl[NUM_CH];
    bit m_tk[NUM_CH];
    bit m_pf[NUM_CH];

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    prog_clock_divider #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEF_DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .sync        (sync),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_div     (cfg_div),
        .clk_out     (clk_out),
        .tick        (tick),
        .cfg_pending (cfg_pending)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic model_step();
        for (int c = 0; c < NUM_CH; c++) begin
            bit wr;
            int nv;
            wr = cfg_we && (int'(cfg_ch) == c);
            m_tk[c] = 1'b0;
            if (rst) begin
                m_n[c] = DEF_DIV; m_pos[c] = 0; m_lvl[c] = 0; m_pf[c] = 0; m_pv[c] = 0;
            end else if (sync) begin
                m_pos[c] = 0; m_lvl[c] = 0;
                if (wr) begin
                    m_n[c] = int'(cfg_div); m_pv[c] = int'(cfg_div); m_pf[c] = 0;
                end else if (m_pf[c]) begin
                    m_n[c] = m_pv[c]; m_pf[c] = 0;
                end
            end else if (m_n[c] == 0) begin
                if (m_pf[c]) begin
                    nv = wr ? int'(cfg_div) : m_pv[c];
                    m_n[c] = nv; m_pv[c] = nv; m_pf[c] = 0;
                end else if (wr) begin
                    m_pv[c] = int'(cfg_div); m_pf[c] = 1;
                end
            end else if (en && (m_pos[c] + 1 == m_n[c])) begin
                // half period complete
                m_pos[c] = 0;
                m_lvl[c] = !m_lvl[c];
                m_tk[c]  = m_lvl[c];
                if (wr || m_pf[c]) begin
                    nv = wr ? int'(cfg_div) : m_pv[c];
                    m_n[c] = nv; m_pv[c] = nv; m_pf[c] = 0;
                    if (nv == 0) begin
                        m_lvl[c] = 0; m_tk[c] = 0;
                    end
                end
            end else begin
                if (en) m_pos[c]++;
                if (wr) begin
                    m_pv[c] = int'(cfg_div); m_pf[c] = 1;
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic cycle();
        logic [NUM_CH-1:0] e_co, e_tk, e_pd;
        @(posedge clk);
        model_step();
        @(negedge clk);
        for (int c = 0; c < NUM_CH; c++) begin
            e_co[c] = m_lvl[c];
            e_pd[c] = m_pf[c];
`ifdef PROG_CLKDIV_TICK_EN
            e_tk[c] = m_tk[c];
`else
            e_tk[c] = 1'b0;
`endif
        end
        check("clk_out", int'(clk_out), int'(e_co));
        check("tick", int'(tick), int'(e_tk));
        check("cfg_pending", int'(cfg_pending), int'(e_pd));
    endtask

    task automatic wr(input int ch, input int div);
        cfg_we  = 1'b1;
        cfg_ch  = CH_W'(ch);
        cfg_div = CNT_W'(div);
        cycle();
        cfg_we  = 1'b0;
    endtask

    // Number of cycles until clk_out[c] changes level; -1 on timeout.
    task automatic cycles_to_toggle(input int c, input int limit, output int k);
        logic prev;
        bit   seen;
        prev = clk_out[c];
        seen = 0;
        k    = 0;
        while (k < limit && !seen) begin
            cycle();
            k++;
            if (clk_out[c] !== prev) seen = 1;
        end
        if (!seen) begin
            check("toggle_timeout", k, -1);
            k = -1;
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int k;
        int pend;
        int ticks;
        int last_rise;
        int first_rise;
        int seq0[4];
        int seq1[4];
        logic [NUM_CH-1:0] snap;
        logic prev0;

        seq0 = '{0, 1, 1, 0};
        seq1 = '{0, 0, 1, 1};

        rst = 1'b1; en = 1'b0; sync = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            m_n[c] = 0; m_pos[c] = 0; m_pv[c] = 0; m_lvl[c] = 0; m_tk[c] = 0; m_pf[c] = 0;
        end

        // Reset state
        cycle();
        check("rst_clk_out", int'(clk_out), 0);
        check("rst_tick", int'(tick), 0);
        check("rst_pending", int'(cfg_pending), 0);
        rst = 1'b0;
        en  = 1'b1;

        // ch0 N=4: period 8, one tick per period, short pending window
        pend = 0;
        wr(0, 4);
        if (cfg_pending[0]) pend++;
        sync = 1'b1;
        cycle();
        sync = 1'b0;
        if (cfg_pending[0]) pend++;
        ticks = 0; last_rise = -1; first_rise = -1;
        prev0 = clk_out[0];
        for (int i = 1; i <= 40; i++) begin
            cycle();
            if (cfg_pending[0]) pend++;
            if (tick[0]) ticks++;
            if (!prev0 && clk_out[0]) begin
                if (first_rise < 0) first_rise = i;
                else check("n4_period", i - last_rise, 8);
                last_rise = i;
            end
            prev0 = clk_out[0];
        end
        check("n4_first_rise", first_rise, 4);
        check("n4_pend_window", int'(pend >= 1 && pend <= 4), 1);
`ifdef PROG_CLKDIV_TICK_EN
        check("n4_ticks", ticks, 5);
`else
        check("n4_ticks", ticks, 0);
`endif

        // ch1 N=3, then N=5 written mid-half-period
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 16'd3; sync = 1'b1;
        cycle();
        cfg_we = 1'b0; sync = 1'b0;
        cycles_to_toggle(1, 10, k);
        check("n3_first_half", k, 3);
        cycle();
        wr(1, 5);
        check("n5_pending_set", int'(cfg_pending[1]), 1);
        cycles_to_toggle(1, 10, k);
        check("n3_old_half_done", k, 1);
        check("n5_pending_drop", int'(cfg_pending[1]), 0);
        cycles_to_toggle(1, 20, k);
        check("n5_half", k, 5);

        // ch0 stop with N=0, then restart with N=2
        wr(0, 0);
        repeat (10) cycle();
        check("stop_pending", int'(cfg_pending[0]), 0);
        check("stop_low", int'(clk_out[0]), 0);
        ticks = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (clk_out[0] || tick[0]) ticks++;
        end
        check("stop_silent", ticks, 0);
        wr(0, 2);
        check("restart_pending", int'(cfg_pending[0]), 1);
        cycle();
        check("restart_applied", int'(cfg_pending[0]), 0);
        cycles_to_toggle(0, 10, k);
        check("restart_first_rise", k, 2);
        cycles_to_toggle(0, 10, k);
        check("restart_fall", k, 2);
        cycles_to_toggle(0, 10, k);
        check("restart_rise", k, 2);

        // sync alignment: ch0 N=2, ch1 N=3 (written with the sync)
        for (int rep = 0; rep < 2; rep++) begin
            repeat ($urandom_range(0, 7)) cycle();
            sync = 1'b1;
            if (rep == 0) begin
                cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 16'd3;
            end
            cycle();
            sync = 1'b0; cfg_we = 1'b0;
            check("sync_zero", int'(clk_out[1:0]), 0);
            for (int i = 0; i < 4; i++) begin
                cycle();
                check("sync_ch0_seq", int'(clk_out[0]), seq0[i]);
                check("sync_ch1_seq", int'(clk_out[1]), seq1[i]);
            end
        end

        // en=0 freeze with an out-of-range write
        repeat (5) cycle();
        snap = clk_out;
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                cfg_we = 1'b1; cfg_ch = 2'd3; cfg_div = 16'd7;
            end
            cycle();
            cfg_we = 1'b0;
            check("freeze_clk_out", int'(clk_out), int'(snap));
            check("freeze_tick", int'(tick), 0);
        end
        check("oob_write_ignored", int'(cfg_pending), 0);
        en = 1'b1;
        repeat (12) cycle();

        // reset while clk_out[0]=1 with same-cycle write and sync
        k = 0;
        while (!clk_out[0] && k < 10) begin
            cycle();
            k++;
        end
        check("pre_rst_high", int'(clk_out[0]), 1);
        rst = 1'b1; cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd5; sync = 1'b1;
        cycle();
        rst = 1'b0; cfg_we = 1'b0; sync = 1'b0;
        check("rst_mid_clk_out", int'(clk_out), 0);
        check("rst_mid_tick", int'(tick), 0);
        check("rst_mid_pending", int'(cfg_pending), 0);
        cycles_to_toggle(0, 20000, k);
        check("rst_default_div", k, DEF_DIV);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            en     = ($urandom_range(0, 99) < 85);
            sync   = ($urandom_range(0, 39) == 0);
            rst    = ($urandom_range(0, 499) == 0);
            cfg_we = ($urandom_range(0, 7) == 0);
            cfg_ch = CH_W'($urandom_range(0, 3));
            cfg_div = CNT_W'($urandom_range(0, 6));
            cycle();
            if (rst) begin
                // restore short divisors so the channels keep moving
                rst = 1'b0; sync = 1'b1; cfg_we = 1'b0;
                cycle();
                sync = 1'b0;
                for (int c = 0; c < NUM_CH; c++) wr(c, $urandom_range(1, 5));
                sync = 1'b1;
                cycle();
                sync = 1'b0;
            end
        end
        rst = 1'b0; sync = 1'b0; cfg_we = 1'b0; en = 1'b1;
        repeat (4) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_clock_divider.md
PROG_CLOCK_DIVIDER -- requirements
Module: prog_clock_divider

Interface
REQ-001 Parameter NUM_CH, default 2: number of independent divided-clock channels, range 1..16.
REQ-002 Parameter CNT_W, default 16: divisor and counter width in bits.
REQ-003 Parameter DEFAULT_DIV, default 16384: per-channel half-period divisor loaded at reset; SHALL be < 2^CNT_W.
REQ-004 clk  in  1  single system clock; all logic on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 en  in  1  global count enable; low freezes all channels.
REQ-007 sync  in  1  one-cycle phase-alignment strobe for all channels.
REQ-008 cfg_we  in  1  divisor write strobe.
REQ-009 cfg_ch  in  max(1,$clog2(NUM_CH))  target channel of the write.
REQ-010 cfg_div  in  CNT_W  new half-period divisor N; 0 means stop.
REQ-011 clk_out  out  NUM_CH  divided clocks, registered.
REQ-012 tick  out  NUM_CH  one-cycle pulse, registered, asserted in the cycle clk_out[i] goes 0->1.
REQ-013 cfg_pending  out  NUM_CH  high while channel i holds an unapplied divisor.

Function
REQ-014 Per channel: active divisor N, counter cnt, pending divisor P, pending flag F.
REQ-015 With en=1 and N!=0, cnt increments each cycle; at cnt==N-1, cnt<=0 and clk_out[i] toggles (the boundary); period = 2N clk cycles, 50% duty.
REQ-016 N=1: clk_out toggles every cycle (clk/2).
REQ-017 First rising edge of clk_out[i] SHALL occur at the Nth enabled edge after reset release.
REQ-018 cfg_we with cfg_ch<NUM_CH: P<=cfg_div, F<=1 next cycle; writes with cfg_ch>=NUM_CH SHALL be ignored.
REQ-019 Pending value applied (N<=P, F<=0) at the next boundary; if N==0, applied on the cycle after the write.
REQ-020 Write in the same cycle as that channel's boundary: the written value SHALL be applied at that boundary (bypass).
REQ-021 A second write before a boundary overwrites P; only the last value is applied.
REQ-022 Applying N=0: clk_out[i]<=0, cnt<=0, channel stopped, tick[i] stays 0.
REQ-023 en=0: cnt, clk_out, N hold; tick=0; writes still captured into P; boundaries cannot occur, so P stays pending unless N==0.
REQ-024 sync=1 (priority over counting, independent of en): all cnt<=0, clk_out<=0, tick<=0; any pending P applied; a same-cycle cfg_we is applied too.
REQ-025 tick[i] SHALL never be high for two consecutive cycles.

Reset
REQ-026 On rst: cnt=0, clk_out=0, tick=0, N=DEFAULT_DIV, P=0, F=0, cfg_pending=0; rst overrides sync and cfg_we.
REQ-027 Reset mid-period SHALL truncate the current half-period, with no glitch pulse on tick.

Configuration
REQ-028 Macro PROG_CLKDIV_TICK_EN defined: tick generated per REQ-012.
REQ-029 Macro undefined: tick tied to 0 and no tick registers synthesised; all other behaviour unchanged.

Structure
REQ-030 Package prog_clock_divider_pkg SHALL hold DEFAULT_DIV default, the max NUM_CH constant and the channel-state typedef {N,cnt,P,F,clk_out}.
REQ-031 One sub-module clkdiv_channel SHALL implement a single channel, instantiated NUM_CH times by generate; top decodes cfg_ch.

Verification
REQ-032 rst 1 cycle, en=1, write ch0 N=4: clk_out[0] period 8 cycles, tick[0] every 8 cycles, cfg_pending[0] high for 1 to 4 cycles.
REQ-033 Ch1 N=3 running; write N=5 mid-half-period: old half-period completes, next half-period 5 cycles, cfg_pending[1] drops at boundary.
REQ-034 Write N=0 to ch0 then N=2: clk_out[0] low and tick silent, then restarts with period 4, first rise 2 enabled edges after apply.
REQ-035 Ch0 N=2, ch1 N=3, sync at arbitrary cycle: both outputs 0 next cycle, then rise after 2 and 3 cycles respectively.
REQ-036 en=0 for 10 cycles mid-count: outputs frozen, tick 0, phase resumes exactly; write cfg_ch=NUM_CH: no channel changes.
REQ-037 rst asserted while clk_out=1 with same-cycle cfg_we and sync: all outputs 0, N=16384, cfg_pending=0.
